point_generator_multi: RTL and testbench
========================================

// Module: point_generator_multi
// PURPOSE
// - Parametrised point (food) generator that keeps NUM_POINTS points live on the map during GAME.
// - Draws candidates from a seedable Galois LFSR and rejects occupied tiles and tiles already holding a live point.
// - Refills each point when the snake logic consumes it.
// - Sits between the game-mode/UART seed logic and the map-update stage, which paints POINT tiles from its outputs.
// PARAMETERS
// - MAP_W      32        map width in tiles; candidate x in [1, MAP_W-2]
// - MAP_H      24        map height in tiles; candidate y in [1, MAP_H-2]
// - NUM_POINTS 2         number of simultaneous points (1..8)
// - LFSR_TAPS  16'hB400  Galois feedback mask of the 16-bit LFSR
// - MAX_TRIES  8         rejected draws before place_fail pulses (>=1)
// - localparam CW = $clog2(max(MAP_W,MAP_H)); 5 with the defaults
// PORTS
// - clk_75        in   1            system clock
// - rst_n         in   1            reset: synchronous, active-low
// - game_active   in   1            1 while mode==GAME
// - seed_load     in   1            load seed_in into the LFSR
// - seed_in       in   16           LFSR seed, local or from UART
// - consume       in   NUM_POINTS   bit i pulse: point i eaten
// - query_x       out  CW           tile x presented to the map
// - query_y       out  CW           tile y presented to the map
// - query_occ     in   1            map tile at query_x/y is non-EMPTY; combinational, same cycle
// - point_x       out  NUM_POINTS*CW packed x coordinates, point i at [i*CW +: CW]
// - point_y       out  NUM_POINTS*CW packed y coordinates
// - point_valid   out  NUM_POINTS   point i is placed
// - busy          out  1            FSM is not in IDLE
// - place_fail    out  1            1-cycle pulse when MAX_TRIES consecutive draws are rejected
// BEHAVIOUR
// - Reset (rst_n==0 at a clk_75 edge) clears all outputs:
//   - point_x/y=0, point_valid=0, busy=0, place_fail=0, query_x/y=0.
//   - pending=0, tries=0, LFSR=16'h0001, state=IDLE.
// - LFSR step: lfsr <= lfsr[0] ? (lfsr>>1)^LFSR_TAPS : lfsr>>1.
//   - seed_load has priority over a step in the same cycle.
//   - A seed of 0 loads 16'h0001.
// - Candidate:
//   - cx = (lfsr[7:0] % (MAP_W-2)) + 1
//   - cy = (lfsr[15:8] % (MAP_H-2)) + 1
//   - Compute in 8-bit, then truncate to CW.
// - pending[i] is set on the rising edge of game_active for all i, and on consume[i] when point_valid[i]==1.
//   - The same consume[i] clears point_valid[i] on that edge.
//   - consume[i] while point_valid[i]==0 is ignored.
// - The FSM always serves the lowest-index pending bit, idx.
// - IDLE:   if game_active and pending!=0 -> DRAW.
// - DRAW:   step the LFSR, register cx/cy into the candidate -> QUERY.
// - QUERY:  query_x/y = candidate.
//   - Reject if query_occ, or if the candidate equals any valid point j!=idx.
//   - On reject: tries++ -> DRAW. If tries reaches MAX_TRIES, pulse place_fail, tries=0 -> DRAW.
//   - On accept -> COMMIT.
// - COMMIT: point_x/y[idx] = candidate, point_valid[idx]=1, pending[idx]=0, tries=0 -> IDLE.
// - Latency: consume sampled at edge t, accepted on the first draw -> point_valid[i]=1 after edge t+4.
//   - Each rejection adds 2 cycles.
// - game_active falling edge, from any state:
//   - point_valid=0, pending=0, tries=0, state=IDLE next cycle.
//   - The LFSR keeps its value.
// - If consume arrives while another point is being refilled, it only sets pending; no draw is aborted.
// - query_x/y hold their last value outside QUERY.
// - Reset mid-operation returns to reset values; no partial commit.
// CONFIGURATION
// - GENPT_MIRROR_EN defined:
//   - Adds input mirror (1 bit).
//   - When mirror==1, point_x/y output MAP_W-1-x / MAP_H-1-y (combinational). This gives the remote player's view.
//   - query_x/y and the collision compare always use unmirrored coordinates.
// - GENPT_MIRROR_EN undefined: no mirror port; outputs are raw coordinates.
// TESTING
// - Reset, then seed_load with seed_in=16'h0000 -> LFSR reads 16'h0001. Assert all outputs 0.
// - seed_in=16'hACE1, game_active 0->1, query_occ=0, NUM_POINTS=2:
//   - Both points valid by cycle 8.
//   - Coordinates match the reference LFSR model.
//   - Point 0 is placed before point 1.
// - query_occ=1 for the first 3 QUERY cycles -> point placed on the 4th draw, 6 extra cycles.
//   - With query_occ held at 1 -> place_fail pulses every 16 cycles (MAX_TRIES=8).
// - consume=2'b11 in one cycle -> both refilled in index order. Second candidate equal to the first -> rejected.
// - game_active 1->0 while in QUERY -> point_valid=0, busy=0 next cycle. Re-entering GAME refills both.
// - GENPT_MIRROR_EN build, point at (5,3), mirror=1 -> outputs (26,20).

Source files
------------

// File: rtl/point_generator_multi.sv
// Keeps NUM_POINTS food points live on the map, drawn from a seedable LFSR.
// Optional remote-player view via GENPT_MIRROR_EN (adds the mirror input).
module point_generator_multi #(
   parameter int          MAP_W      = 32,
   parameter int          MAP_H      = 24,
   parameter int          NUM_POINTS = 2,
   parameter logic [15:0] LFSR_TAPS  = 16'hB400,
   parameter int          MAX_TRIES  = 8,
   localparam int         CW = $clog2((MAP_W > MAP_H) ? MAP_W : MAP_H)
) (
   input  logic                     clk_75,
   input  logic                     rst_n,
   input  logic                     game_active,
   input  logic                     seed_load,
   input  logic [15:0]              seed_in,
   input  logic [NUM_POINTS-1:0]    consume,
   output logic [CW-1:0]            query_x,
   output logic [CW-1:0]            query_y,
   input  logic                     query_occ,
   output logic [NUM_POINTS*CW-1:0] point_x,
   output logic [NUM_POINTS*CW-1:0] point_y,
   output logic [NUM_POINTS-1:0]    point_valid,
   output logic                     busy,
`ifdef GENPT_MIRROR_EN
   input  logic                     mirror,
`endif
   output logic                     place_fail
);

   localparam int IW = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam logic [7:0] WM = 8'(MAP_W - 2);
   localparam logic [7:0] HM = 8'(MAP_H - 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAW,
      S_QUERY,
      S_COMMIT
   } state_t;

   state_t                  state_q, state_d;
   logic [15:0]             lfsr_q, lfsr_d;
   logic [CW-1:0]           cx_q, cx_d;
   logic [CW-1:0]           cy_q, cy_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [TW-1:0]           tries_q, tries_d;
   logic [NUM_POINTS-1:0]   pend_q, pend_d;
   logic [NUM_POINTS-1:0]   vld_q, vld_d;
   logic [NUM_POINTS*CW-1:0] px_q, px_d;
   logic [NUM_POINTS*CW-1:0] py_q, py_d;
   logic                    fail_q, fail_d;
   logic                    ga_q;

   logic [IW-1:0]           low_idx;
   logic                    hit;
   logic                    rise;
   logic                    fall;
   logic                    step_en;
   logic [NUM_POINTS-1:0]   eat;

   assign rise = game_active & ~ga_q;
   assign fall = ~game_active & ga_q;
   assign eat  = consume & vld_q;

   // Lowest pending index and collision with another live point
   always_comb begin
      low_idx = '0;
      hit     = 1'b0;
      for (int i = NUM_POINTS - 1; i >= 0; i--) begin
         if (pend_q[i]) low_idx = IW'(i);
      end
      for (int j = 0; j < NUM_POINTS; j++) begin
         if (vld_q[j] && (IW'(j) != idx_q) &&
             (px_q[j*CW +: CW] == cx_q) &&
             (py_q[j*CW +: CW] == cy_q)) hit = 1'b1;
      end
   end

   // Next-state logic: FSM, pending/valid bookkeeping, LFSR
   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      idx_d   = idx_q;
      tries_d = tries_q;
      px_d    = px_q;
      py_d    = py_q;
      fail_d  = 1'b0;
      step_en = 1'b0;
      vld_d   = vld_q & ~eat;
      pend_d  = pend_q | eat;
      if (rise) pend_d = '1;
      unique case (state_q)
         S_IDLE: begin
            if (game_active && (pend_q != '0)) begin
               idx_d   = low_idx;
               state_d = S_DRAW;
            end
         end
         S_DRAW: begin
            step_en = 1'b1;
            cx_d    = CW'((lfsr_q[7:0] % WM) + 8'd1);
            cy_d    = CW'((lfsr_q[15:8] % HM) + 8'd1);
            state_d = S_QUERY;
         end
         S_QUERY: begin
            if (query_occ || hit) begin
               state_d = S_DRAW;
               if (tries_q == TW'(MAX_TRIES - 1)) begin
                  fail_d  = 1'b1;
                  tries_d = '0;
               end else begin
                  tries_d = tries_q + 1'b1;
               end
            end else begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            px_d[idx_q*CW +: CW] = cx_q;
            py_d[idx_q*CW +: CW] = cy_q;
            vld_d[idx_q]  = 1'b1;
            pend_d[idx_q] = 1'b0;
            tries_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (fall) begin
         vld_d   = '0;
         pend_d  = '0;
         tries_d = '0;
         fail_d  = 1'b0;
         step_en = 1'b0;
         state_d = S_IDLE;
      end
      if (seed_load) begin
         lfsr_d = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
      end else if (step_en) begin
         lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk_75) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lfsr_q  <= 16'h0001;
         cx_q    <= '0;
         cy_q    <= '0;
         idx_q   <= '0;
         tries_q <= '0;
         pend_q  <= '0;
         vld_q   <= '0;
         px_q    <= '0;
         py_q    <= '0;
         fail_q  <= 1'b0;
         ga_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         idx_q   <= idx_d;
         tries_q <= tries_d;
         pend_q  <= pend_d;
         vld_q   <= vld_d;
         px_q    <= px_d;
         py_q    <= py_d;
         fail_q  <= fail_d;
         ga_q    <= game_active;
      end
   end

   assign query_x     = cx_q;
   assign query_y     = cy_q;
   assign point_valid = vld_q;
   assign busy        = (state_q != S_IDLE);
   assign place_fail  = fail_q;

`ifdef GENPT_MIRROR_EN
   // Remote view: flip each coordinate about the map centre
   always_comb begin
      for (int i = 0; i < NUM_POINTS; i++) begin
         point_x[i*CW +: CW] = mirror ?
            CW'(MAP_W - 1) - px_q[i*CW +: CW] : px_q[i*CW +: CW];
         point_y[i*CW +: CW] = mirror ?
            CW'(MAP_H - 1) - py_q[i*CW +: CW] : py_q[i*CW +: CW];
      end
   end
`else
   assign point_x = px_q;
   assign point_y = py_q;
`endif

endmodule

// File: tb/tb_point_generator_multi.sv
// Directed self-checking bench for point_generator_multi (default build).
// Uses the default parameters: 32x24 map, two points, MAX_TRIES=8.
module tb_point_generator_multi;

   logic        clk_75 = 1'b0;
   logic        rst_n;
   logic        game_active;
   logic        seed_load;
   logic [15:0] seed_in;
   logic [1:0]  consume;
   logic [4:0]  query_x, query_y;
   logic        query_occ;
   logic [9:0]  point_x, point_y;
   logic [1:0]  point_valid;
   logic        busy;
   logic        place_fail;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_lfsr;
   logic [4:0]  mx [2];
   logic [4:0]  my [2];
   logic [1:0]  mvld;

   always #5 clk_75 = ~clk_75;

   point_generator_multi dut (
      .clk_75      (clk_75),
      .rst_n       (rst_n),
      .game_active (game_active),
      .seed_load   (seed_load),
      .seed_in     (seed_in),
      .consume     (consume),
      .query_x     (query_x),
      .query_y     (query_y),
      .query_occ   (query_occ),
      .point_x     (point_x),
      .point_y     (point_y),
      .point_valid (point_valid),
      .busy        (busy),
      .place_fail  (place_fail)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_75);
         #1;
      end
   endtask

   function automatic logic [15:0] lstep(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic logic [4:0] fcx(input logic [15:0] v);
      logic [7:0] t;
      t = (v[7:0] % 8'd30) + 8'd1;
      return t[4:0];
   endfunction

   function automatic logic [4:0] fcy(input logic [15:0] v);
      logic [7:0] t;
      t = (v[15:8] % 8'd22) + 8'd1;
      return t[4:0];
   endfunction

   // Reference placement with query_occ low: draw until no live clash
   task automatic mplace(input int i);
      logic [4:0] x, y;
      for (int k = 0; k < 64; k++) begin
         x = fcx(m_lfsr);
         y = fcy(m_lfsr);
         m_lfsr = lstep(m_lfsr);
         if (!(mvld[1-i] && mx[1-i] == x && my[1-i] == y)) begin
            mx[i] = x;
            my[i] = y;
            mvld[i] = 1'b1;
            break;
         end
      end
   endtask

   task automatic chk_pts(input string tag);
      chk({tag, "_x0"}, point_x[4:0], mx[0]);
      chk({tag, "_y0"}, point_y[4:0], my[0]);
      chk({tag, "_x1"}, point_x[9:5], mx[1]);
      chk({tag, "_y1"}, point_y[9:5], my[1]);
   endtask

   initial begin
      int t0, t1, n;
      logic [15:0] s_seed;
      logic found;

      rst_n = 1'b0;
      game_active = 1'b0;
      seed_load = 1'b0;
      seed_in = 16'h0;
      consume = 2'b00;
      query_occ = 1'b0;
      mvld = 2'b00;
      tick(2);
      chk("rst_px", point_x, 0);
      chk("rst_py", point_y, 0);
      chk("rst_valid", point_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fail", place_fail, 0);
      chk("rst_qx", query_x, 0);
      chk("rst_qy", query_y, 0);
      chk("rst_lfsr", dut.lfsr_q, 16'h0001);

      rst_n = 1'b1;
      seed_load = 1'b1;
      seed_in = 16'hACE1;
      tick();
      chk("seed_ace1", dut.lfsr_q, 16'hACE1);
      seed_in = 16'h0000;
      tick();
      chk("seed_zero", dut.lfsr_q, 16'h0001);

      seed_in = 16'hACE1;
      tick();
      seed_load = 1'b0;
      game_active = 1'b1;
      t0 = 0;
      t1 = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (point_valid[0] && t0 == 0) begin
            t0 = k;
            chk("p0_first_x", point_x[4:0], 16);
            chk("p0_first_y", point_y[4:0], 19);
            chk("p1_not_yet", point_valid[1], 0);
         end
         if (point_valid[1] && t1 == 0) t1 = k;
         if (point_valid == 2'b11) break;
      end
      chk("start_t0", t0, 5);
      chk("start_t1", t1, 9);
      mx[0] = 5'd16; my[0] = 5'd19;
      mx[1] = 5'd23; my[1] = 5'd7;
      mvld = 2'b11;
      chk_pts("start");
      chk("start_busy", busy, 0);
      chk("hold_qx", query_x, 23);
      chk("hold_qy", query_y, 7);
      chk("start_lfsr", dut.lfsr_q, 16'h7138);

      consume = 2'b01;
      tick();
      consume = 2'b00;
      query_occ = 1'b1;
      chk("eat0_clear", point_valid, 2'b10);
      tick(7);
      query_occ = 1'b0;
      tick(2);
      chk("rej3_t9", point_valid, 2'b10);
      tick();
      chk("rej3_t10", point_valid, 2'b11);
      mx[0] = 5'd10; my[0] = 5'd15;
      chk_pts("rej3");
      chk("rej3_lfsr", dut.lfsr_q, 16'hB313);

      consume = 2'b01;
      tick();
      consume = 2'b00;
      query_occ = 1'b1;
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         n = k;
         if (place_fail) break;
      end
      chk("fail_first", n, 17);
      tick();
      chk("fail_pulse1", place_fail, 0);
      n = 1;
      for (int k = 2; k <= 40; k++) begin
         tick();
         n = k;
         if (place_fail) break;
      end
      chk("fail_period", n, 16);
      query_occ = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (point_valid == 2'b11) break;
      end
      chk("fail_recover", point_valid, 2'b11);
      chk("fail_distinct",
          (point_x[4:0] == point_x[9:5]) && (point_y[4:0] == point_y[9:5]), 0);

      found = 1'b0;
      s_seed = 16'h0001;
      for (int s = 1; s < 65536; s++) begin
         logic [15:0] v;
         v = 16'(s);
         if (fcx(v) == fcx(lstep(v)) && fcy(v) == fcy(lstep(v))) begin
            s_seed = v;
            found = 1'b1;
            break;
         end
      end
      chk("seed_found", found, 1);
      seed_load = 1'b1;
      seed_in = s_seed;
      tick();
      seed_load = 1'b0;
      m_lfsr = s_seed;
      mvld = 2'b00;
      consume = 2'b11;
      tick();
      consume = 2'b00;
      chk("both_clear", point_valid, 2'b00);
      mplace(0);
      mplace(1);
      tick(4);
      chk("dup_p0", point_valid, 2'b01);
      chk("dup_p0x", point_x[4:0], mx[0]);
      tick(2);
      chk("dup_qx", query_x, mx[0]);
      chk("dup_qy", query_y, my[0]);
      tick(3);
      chk("dup_t9", point_valid, 2'b01);
      tick();
      chk("dup_t10", point_valid, 2'b11);
      chk_pts("dup");

      consume = 2'b01;
      tick();
      consume = 2'b00;
      tick(2);
      chk("abort_busy", busy, 1);
      game_active = 1'b0;
      tick();
      m_lfsr = lstep(m_lfsr);
      mvld = 2'b00;
      chk("abort_valid", point_valid, 2'b00);
      chk("abort_busy0", busy, 0);
      chk("abort_lfsr", dut.lfsr_q, m_lfsr);
      tick(2);
      chk("abort_idle", busy, 0);
      game_active = 1'b1;
      mplace(0);
      mplace(1);
      for (int k = 0; k < 20; k++) begin
         tick();
         if (point_valid == 2'b11) break;
      end
      chk("reenter", point_valid, 2'b11);
      chk_pts("reenter");

      consume = 2'b10;
      tick();
      consume = 2'b00;
      tick(2);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid", point_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_px", point_x, 0);
      chk("mid_rst_qx", query_x, 0);
      chk("mid_rst_lfsr", dut.lfsr_q, 16'h0001);
      rst_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
